// File: rtl/test_status_monitor_if.sv
// Tohost write channel between a test driver (master) and the status monitor (slave).
//   wr_valid : master offers a tohost write this cycle
//   wr_data  : tohost write value, DATA_W bits
//   wr_ready : slave accepts the offered write this cycle
interface test_status_monitor_if #(
  parameter int unsigned DATA_W = 64
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/test_status_monitor.sv
// Test status monitor: watches tohost writes and reports pass/fail to the test driver.
// After reset release it waits ARM_DELAY cycles (HOLD), then accepts writes (RUN).
// A write with bit0=1 ends the test: upper field zero -> PASS, nonzero -> FAIL.
// A write with bit0=0 is counted as ignored. PASS and FAIL are left only by reset.
// Optional macro TEST_MONITOR_TIMEOUT_EN adds port max_cycles and a RUN-cycle timeout
// that fails the test with reason=2.
// Ports:
//   clock, reset   : single clock, synchronous active-high reset
//   wr_if (slave)  : tohost write channel (wr_valid, wr_data, wr_ready)
//   max_cycles     : timeout limit, 0 disables (TEST_MONITOR_TIMEOUT_EN only)
//   success        : sticky pass indication
//   failure        : sticky fail indication
//   reason         : 0 none, 1 test-reported, 2 timeout
//   fail_code      : wr_data[DATA_W-1:1] of the failing write
//   cycle_count    : cycles spent in RUN (saturating)
//   ignored_count  : accepted writes with bit0=0 (saturating)
module test_status_monitor #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ARM_DELAY = 4
) (
  input  logic                clock,
  input  logic                reset,
  test_status_monitor_if.slave wr_if,
`ifdef TEST_MONITOR_TIMEOUT_EN
  input  logic [63:0]         max_cycles,
`endif
  output logic                success,
  output logic                failure,
  output logic [1:0]          reason,
  output logic [DATA_W-2:0]   fail_code,
  output logic [63:0]         cycle_count,
  output logic [15:0]         ignored_count
);

  localparam int unsigned CODE_W = DATA_W - 1;
  localparam int unsigned ARM_W  = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned IGN_W  = 16;

  localparam logic [ARM_W-1:0] ARM_LAST       = ARM_W'(ARM_DELAY - 1);
  localparam logic [1:0]       REASON_NONE    = 2'd0;
  localparam logic [1:0]       REASON_TEST    = 2'd1;
`ifdef TEST_MONITOR_TIMEOUT_EN
  localparam logic [1:0]       REASON_TIMEOUT = 2'd2;
`endif

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic               wr_ready_q, wr_ready_d;
  logic               success_q, success_d;
  logic               failure_q, failure_d;
  logic [1:0]         reason_q, reason_d;
  logic [CODE_W-1:0]  fail_code_q, fail_code_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [IGN_W-1:0]   ignored_count_q, ignored_count_d;

  logic               accept;
  logic               wr_lsb;
  logic [CODE_W-1:0]  wr_upper;

  // wr_ready is registered, so acceptance needs no combinational state decode
  assign accept   = wr_if.wr_valid && wr_ready_q;
  assign wr_lsb   = wr_if.wr_data[0];
  assign wr_upper = wr_if.wr_data[DATA_W-1:1];

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    arm_cnt_d       = arm_cnt_q;
    success_d       = success_q;
    failure_d       = failure_q;
    reason_d        = reason_q;
    fail_code_d     = fail_code_q;
    cycle_count_d   = cycle_count_q;
    ignored_count_d = ignored_count_q;

    case (state_q)
      HOLD: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = RUN;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end

      RUN: begin
        if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        // A terminating write takes priority over a same-cycle timeout
        if (accept && wr_lsb) begin
          if (wr_upper == '0) begin
            state_d   = PASS;
            success_d = 1'b1;
          end else begin
            state_d     = FAIL;
            failure_d   = 1'b1;
            reason_d    = REASON_TEST;
            fail_code_d = wr_upper;
          end
        end else begin
          if (accept && (ignored_count_q != '1)) begin
            ignored_count_d = ignored_count_q + IGN_W'(1);
          end
`ifdef TEST_MONITOR_TIMEOUT_EN
          // Fires on the RUN cycle that brings cycle_count up to max_cycles
          if ((max_cycles != '0) && (cycle_count_q == max_cycles - CNT_W'(1))) begin
            state_d   = FAIL;
            failure_d = 1'b1;
            reason_d  = REASON_TIMEOUT;
          end
`endif
        end
      end

      PASS, FAIL: begin
        state_d = state_q;
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    wr_ready_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= HOLD;
      arm_cnt_q       <= '0;
      wr_ready_q      <= 1'b0;
      success_q       <= 1'b0;
      failure_q       <= 1'b0;
      reason_q        <= REASON_NONE;
      fail_code_q     <= '0;
      cycle_count_q   <= '0;
      ignored_count_q <= '0;
    end else begin
      state_q         <= state_d;
      arm_cnt_q       <= arm_cnt_d;
      wr_ready_q      <= wr_ready_d;
      success_q       <= success_d;
      failure_q       <= failure_d;
      reason_q        <= reason_d;
      fail_code_q     <= fail_code_d;
      cycle_count_q   <= cycle_count_d;
      ignored_count_q <= ignored_count_d;
    end
  end

  assign wr_if.wr_ready = wr_ready_q;
  assign success        = success_q;
  assign failure        = failure_q;
  assign reason         = reason_q;
  assign fail_code      = fail_code_q;
  assign cycle_count    = cycle_count_q;
  assign ignored_count  = ignored_count_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: directed scenarios plus randomized episodes,
// all checked every cycle against a cycle-level behavioural model.
// Builds with or without TEST_MONITOR_TIMEOUT_EN.
module tb_test_status_monitor;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ARM_DELAY = 4;

  logic              clock;
  logic              reset;
  logic              success;
  logic              failure;
  logic [1:0]        reason;
  logic [DATA_W-2:0] fail_code;
  logic [63:0]       cycle_count;
  logic [15:0]       ignored_count;
`ifdef TEST_MONITOR_TIMEOUT_EN
  logic [63:0]       mc;
`endif

  int total;
  int bad;

  test_status_monitor_if #(.DATA_W(DATA_W)) ifc ();

  test_status_monitor #(
    .DATA_W    (DATA_W),
    .ARM_DELAY (ARM_DELAY)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_if         (ifc),
`ifdef TEST_MONITOR_TIMEOUT_EN
    .max_cycles    (mc),
`endif
    .success       (success),
    .failure       (failure),
    .reason        (reason),
    .fail_code     (fail_code),
    .cycle_count   (cycle_count),
    .ignored_count (ignored_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: how many cycles since release, and how the test ended (0 running, 1 pass, 2 fail)
  int          m_since;
  int          m_done;
  logic [63:0] m_run;
  int          m_ign;
  int          m_reason;
  logic [63:0] m_code;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input logic rst, input logic vld, input logic [63:0] d);
    logic [63:0] run_pre;
    if (rst) begin
      m_since = 0; m_done = 0; m_run = 0; m_ign = 0; m_reason = 0; m_code = 0;
    end else if (m_since < ARM_DELAY) begin
      m_since++;
    end else if (m_done == 0) begin
      run_pre = m_run;
      if (m_run != 64'hFFFF_FFFF_FFFF_FFFF) m_run = m_run + 64'd1;
      if (vld && d[0]) begin
        if ((d >> 1) == 64'd0) m_done = 1;
        else begin
          m_done = 2; m_reason = 1; m_code = d >> 1;
        end
      end else begin
        if (vld && m_ign < 65535) m_ign++;
`ifdef TEST_MONITOR_TIMEOUT_EN
        if (mc != 64'd0 && run_pre + 64'd1 == mc) begin
          m_done = 2; m_reason = 2;
        end
`endif
      end
    end
  endfunction

  task automatic compare_all();
    check("wr_ready", 64'(ifc.wr_ready), 64'((m_since >= ARM_DELAY) && (m_done == 0)));
    check("success", 64'(success), 64'(m_done == 1));
    check("failure", 64'(failure), 64'(m_done == 2));
    check("reason", 64'(reason), 64'(m_reason));
    check("fail_code", 64'(fail_code), m_code);
    check("cycle_count", cycle_count, m_run);
    check("ignored_count", 64'(ignored_count), 64'(m_ign));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare
  task automatic step(input logic rst, input logic vld, input logic [63:0] d);
    reset        = rst;
    ifc.wr_valid = vld;
    ifc.wr_data  = d;
    @(posedge clock);
    model_edge(rst, vld, d);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    int          ncyc;
    int          r;
    total = 0;
    bad   = 0;
    m_since = 0; m_done = 0; m_run = 0; m_ign = 0; m_reason = 0; m_code = 0;
    reset        = 1'b1;
    ifc.wr_valid = 1'b0;
    ifc.wr_data  = '0;
`ifdef TEST_MONITOR_TIMEOUT_EN
    mc = 64'd0;
`endif
    #2;

    // Pass with wr_valid held from reset release
    step(1'b1, 1'b0, 64'd0);
    for (int i = 0; i < ARM_DELAY; i++) begin
      check("hold_ready", 64'(ifc.wr_ready), 64'd0);
      step(1'b0, 1'b1, 64'd1);
    end
    check("armed_ready", 64'(ifc.wr_ready), 64'd1);
    step(1'b0, 1'b1, 64'd1);
    check("pass_success", 64'(success), 64'd1);
    check("pass_failure", 64'(failure), 64'd0);
    check("pass_cycles", cycle_count, 64'd1);
    step(1'b0, 1'b1, 64'h2B);
    check("pass_sticky", 64'(failure), 64'd0);

    // Test-reported failure, later pass write has no effect
    step(1'b1, 1'b0, 64'd0);
    idle(ARM_DELAY);
    step(1'b0, 1'b1, 64'h2B);
    check("fail_failure", 64'(failure), 64'd1);
    check("fail_reason", 64'(reason), 64'd1);
    check("fail_code", 64'(fail_code), 64'h15);
    check("fail_ready", 64'(ifc.wr_ready), 64'd0);
    step(1'b0, 1'b1, 64'd1);
    check("fail_no_pass", 64'(success), 64'd0);

    // Reset while in FAIL, then a normal pass
    step(1'b1, 1'b0, 64'd0);
    check("rst_failure", 64'(failure), 64'd0);
    check("rst_code", 64'(fail_code), 64'd0);
    idle(ARM_DELAY - 1);
    check("rearm_ready_low", 64'(ifc.wr_ready), 64'd0);
    idle(1);
    step(1'b0, 1'b1, 64'd1);
    check("rearm_pass", 64'(success), 64'd1);

    // Ignored writes then pass; offers during HOLD are not counted
    step(1'b1, 1'b0, 64'd0);
    for (int i = 0; i < ARM_DELAY; i++) step(1'b0, 1'b1, 64'h10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'h10);
    step(1'b0, 1'b1, 64'd1);
    check("ign_count", 64'(ignored_count), 64'd3);
    check("ign_success", 64'(success), 64'd1);

`ifdef TEST_MONITOR_TIMEOUT_EN
    // Timeout with no writes
    mc = 64'd100;
    step(1'b1, 1'b0, 64'd0);
    idle(ARM_DELAY + 99);
    check("to_not_yet", 64'(failure), 64'd0);
    idle(1);
    check("to_failure", 64'(failure), 64'd1);
    check("to_reason", 64'(reason), 64'd2);
    check("to_cycles", cycle_count, 64'd100);
    // Pass write on the 100th RUN cycle wins
    step(1'b1, 1'b0, 64'd0);
    idle(ARM_DELAY + 99);
    step(1'b0, 1'b1, 64'd1);
    check("to_pass_success", 64'(success), 64'd1);
    check("to_pass_failure", 64'(failure), 64'd0);
    // Ignored write on the 100th RUN cycle does not block the timeout
    step(1'b1, 1'b0, 64'd0);
    idle(ARM_DELAY + 99);
    step(1'b0, 1'b1, 64'h10);
    check("to_ign_reason", 64'(reason), 64'd2);
    check("to_ign_count", 64'(ignored_count), 64'd1);
`endif

    // Randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
`ifdef TEST_MONITOR_TIMEOUT_EN
      mc = 64'($urandom_range(0, 40));
`endif
      step(1'b1, 1'($urandom_range(0, 1)), 64'd1);
      ncyc = $urandom_range(5, 60);
      for (int c = 0; c < ncyc; c++) begin
        r = $urandom_range(0, 19);
        d = {$urandom(), $urandom()};
        if (r == 0)      d = 64'd1;
        else if (r == 1) d = d | 64'h3;
        else             d = d & ~64'h1;
        step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_status_monitor.md
TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 Parameter DATA_W, default 64, meaning tohost write data width (minimum 2).
REQ-002 Parameter ARM_DELAY, default 4, meaning cycles after reset release before writes are accepted (minimum 1).
REQ-003 Port clock, input, 1, meaning the single clock; every flop is clocked on its rising edge.
REQ-004 Port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 Port wr_valid, input, 1, meaning a tohost write is offered.
REQ-006 Port wr_ready, output, 1, meaning the monitor accepts the write offered in this cycle.
REQ-007 Port wr_data, input, DATA_W, meaning the tohost write value.
REQ-008 Port max_cycles, input, 64, meaning the timeout limit; 0 disables the timeout (present only under TEST_MONITOR_TIMEOUT_EN).
REQ-009 Port success, output, 1, meaning sticky pass indication to the test driver.
REQ-010 Port failure, output, 1, meaning sticky fail indication to the test driver.
REQ-011 Port reason, output, 2, meaning failure cause: 0 none, 1 test-reported, 2 timeout.
REQ-012 Port fail_code, output, DATA_W-1, meaning wr_data[DATA_W-1:1] of the failing write.
REQ-013 Port cycle_count, output, 64, meaning the number of cycles spent in RUN.
REQ-014 Port ignored_count, output, 16, meaning the number of accepted writes with wr_data[0]==0.

Function
REQ-015 The state machine SHALL have exactly four states: HOLD, RUN, PASS and FAIL.
REQ-016 HOLD SHALL count ARM_DELAY cycles and then move to RUN; wr_ready SHALL be 0 throughout HOLD.
REQ-017 wr_ready SHALL be 1 in RUN and 0 in HOLD, PASS and FAIL; the output SHALL be a registered state decode, independent of wr_valid.
REQ-018 A write SHALL be accepted only in a cycle where wr_valid and wr_ready are both 1.
REQ-019 An accepted write with wr_data[0]==1 and wr_data[DATA_W-1:1]==0 SHALL move the FSM to PASS, with success=1 on the next cycle.
REQ-020 An accepted write with wr_data[0]==1 and a nonzero upper field SHALL move the FSM to FAIL with reason=1, and SHALL latch fail_code=wr_data[DATA_W-1:1]; both become visible on the next cycle.
REQ-021 An accepted write with wr_data[0]==0 SHALL leave the state unchanged and increment ignored_count; ignored_count SHALL saturate at 16'hFFFF.
REQ-022 cycle_count SHALL increment once per cycle in RUN only, SHALL freeze in PASS and FAIL, and SHALL saturate at all-ones.
REQ-023 PASS and FAIL SHALL be terminal: only reset leaves them, and success and failure SHALL never both be 1.
REQ-024 Writes offered while wr_ready=0 SHALL be ignored, with no effect on any counter.

Reset
REQ-025 While reset=1 at a rising clock edge, the FSM SHALL enter HOLD and the ARM_DELAY counter SHALL clear.
REQ-026 At the same edge, success, failure, wr_ready, reason, fail_code, cycle_count and ignored_count SHALL all be forced to 0.
REQ-027 Reset asserted mid-test, including in PASS or FAIL, SHALL apply the same behaviour and restart the ARM_DELAY count after release.

Configuration
REQ-028 With TEST_MONITOR_TIMEOUT_EN defined, the port max_cycles SHALL exist.
REQ-029 With TEST_MONITOR_TIMEOUT_EN defined, the FSM SHALL go from RUN to FAIL with reason=2 when max_cycles!=0 and the pre-increment cycle_count equals max_cycles-1; failure SHALL then be 1 on the next cycle, with cycle_count==max_cycles.
REQ-030 With TEST_MONITOR_TIMEOUT_EN defined, if a write is accepted in the same cycle the timeout fires, the write SHALL take priority (pass, fail or ignore as decoded); an ignored write SHALL not block the timeout.
REQ-031 With TEST_MONITOR_TIMEOUT_EN undefined, the max_cycles port and the timeout logic SHALL be absent, and reason SHALL never equal 2.

Verification
REQ-032 Pass: after reset release, hold wr_valid=1 with wr_data=1 -> wr_ready rises on cycle ARM_DELAY; success=1 the cycle after acceptance; cycle_count==1; failure=0.
REQ-033 Fail: accept wr_data=0x2B (code 0x15) -> failure=1, reason=1, fail_code=0x15; wr_ready=0 thereafter; a later wr_data=1 changes nothing.
REQ-034 Ignored writes: accept wr_data=0x10 three times, then wr_data=1 -> ignored_count==3 and success=1.
REQ-035 Timeout (macro defined): max_cycles=100 with no writes -> failure=1, reason=2, cycle_count==100; repeat with wr_data=1 accepted on the 100th RUN cycle -> success=1, failure=0.
REQ-036 Reset mid-test: assert reset for one cycle while in FAIL -> all outputs 0 on the next cycle, wr_ready=0 for ARM_DELAY cycles, then a new pass completes normally.
